// File: rtl/fir_pkg.sv
// Shared filter definitions: default sample width, kernel taps and FSM state type.
// Used by fir_interp2 and the existing low-pass filter.
package fir_pkg;

  localparam int SIGNAL_SIZE_DEF = 8;

  // Kernel [1 2 4 2 1]; even phase uses taps 0/2/4, odd phase uses taps 1/3.
  localparam int TAP0 = 1;
  localparam int TAP1 = 2;
  localparam int TAP2 = 4;
  localparam int TAP3 = 2;
  localparam int TAP4 = 1;

  typedef enum logic [1:0] {
    WAIT_IN   = 2'd0,
    EMIT_EVEN = 2'd1,
    EMIT_ODD  = 2'd2
  } fir_state_e;

endpackage

// File: rtl/fir_interp2.sv
// 2x polyphase interpolator for the zero-stuffed kernel [1 2 4 2 1].
// One input produces an even then an odd output, with ready/valid on both sides.
module fir_interp2
  import fir_pkg::*;
#(
  parameter int SIGNAL_SIZE = SIGNAL_SIZE_DEF,
  parameter int OUT_W       = SIGNAL_SIZE + 3
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic signed [SIGNAL_SIZE-1:0] in_data,
  input  logic                          in_valid,
  output logic                          in_ready,
  output logic signed [OUT_W-1:0]       out_data,
  output logic                          out_valid,
  input  logic                          out_ready
);

  if (OUT_W < SIGNAL_SIZE + 3) begin : g_bad_width
    $error("fir_interp2: OUT_W must be at least SIGNAL_SIZE+3");
  end

  localparam logic signed [OUT_W-1:0] K0 = OUT_W'(TAP0);
  localparam logic signed [OUT_W-1:0] K1 = OUT_W'(TAP1);
  localparam logic signed [OUT_W-1:0] K2 = OUT_W'(TAP2);
  localparam logic signed [OUT_W-1:0] K3 = OUT_W'(TAP3);
  localparam logic signed [OUT_W-1:0] K4 = OUT_W'(TAP4);

  fir_state_e                    state_q, state_d;
  logic signed [SIGNAL_SIZE-1:0] h0_q, h1_q, h2_q;
  logic signed [SIGNAL_SIZE-1:0] h0_d, h1_d, h2_d;
  logic signed [OUT_W-1:0]       out_data_q, out_data_d;
  logic                          accept;

  function automatic logic signed [OUT_W-1:0] sx(input logic signed [SIGNAL_SIZE-1:0] v);
    return {{(OUT_W-SIGNAL_SIZE){v[SIGNAL_SIZE-1]}}, v};
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= WAIT_IN;
      h0_q       <= '0;
      h1_q       <= '0;
      h2_q       <= '0;
      out_data_q <= '0;
    end else begin
      state_q    <= state_d;
      h0_q       <= h0_d;
      h1_q       <= h1_d;
      h2_q       <= h2_d;
      out_data_q <= out_data_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      WAIT_IN:   if (in_valid) state_d = EMIT_EVEN;
      EMIT_EVEN: if (out_ready) state_d = EMIT_ODD;
      EMIT_ODD:  if (out_ready) state_d = in_valid ? EMIT_EVEN : WAIT_IN;
      default:   state_d = WAIT_IN;
    endcase
  end

  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (state_q)
      WAIT_IN:   in_ready = 1'b1;
      EMIT_EVEN: out_valid = 1'b1;
      EMIT_ODD: begin
        out_valid = 1'b1;
        in_ready  = out_ready;
      end
      default: ;
    endcase
  end

  assign accept   = in_valid && in_ready;
  assign out_data = out_data_q;

  // Even phase is evaluated on the post-shift history (in_data, h0, h1) so it
  // can be registered in the same cycle the sample is accepted.
  always_comb begin
    h0_d       = h0_q;
    h1_d       = h1_q;
    h2_d       = h2_q;
    out_data_d = out_data_q;
    if (accept) begin
      h0_d       = in_data;
      h1_d       = h0_q;
      h2_d       = h1_q;
      out_data_d = sx(in_data) * K0 + sx(h0_q) * K2 + sx(h1_q) * K4;
    end else if (state_q == EMIT_EVEN && out_ready) begin
      out_data_d = sx(h0_q) * K1 + sx(h1_q) * K3;
    end
  end

endmodule

// File: tb/tb_fir_interp2.sv
// Directed bench for fir_interp2: convolution model of the zero-stuffed stream
// plus literal expectations for impulse, DC, extremes, backpressure, reset and idle gaps.
module tb_fir_interp2;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic signed [7:0] in_data = '0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic signed [10:0] out_data;
  logic              out_valid;
  logic              out_ready = 1'b1;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_q[$];
  int log_q[$];
  int u_q[$];
  bit streaming = 1'b0;
  int bubbles = 0;

  fir_interp2 #(.SIGNAL_SIZE(8), .OUT_W(11)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Output m of the upsampled stream u filtered by [1 2 4 2 1].
  function automatic int conv(input int m);
    int taps[5] = '{1, 2, 4, 2, 1};
    int acc = 0;
    for (int k = 0; k < 5; k++)
      if (m - k >= 0) acc += taps[k] * u_q[m - k];
    return acc;
  endfunction

  function automatic void model_reset();
    exp_q.delete();
    u_q = '{0, 0, 0, 0};
  endfunction

  // Compare process: expected handshakes derived from the queue of pending outputs.
  initial begin : compare
    bit exp_ir;
    int m;
    model_reset();
    forever begin
      @(negedge clk);
      if (rst) begin
        model_reset();
      end else begin
        exp_ir = (exp_q.size() == 0) || (exp_q.size() == 1 && out_ready);
        check("out_valid", int'(out_valid), int'(exp_q.size() > 0));
        check("in_ready", int'(in_ready), int'(exp_ir));
        if (streaming && !out_valid) bubbles++;
        if (exp_q.size() > 0) begin
          check("out_data", int'(out_data), exp_q[0]);
          if (out_ready) begin
            log_q.push_back(int'(out_data));
            void'(exp_q.pop_front());
          end
        end
        if (in_valid && exp_ir) begin
          u_q.push_back(int'(in_data));
          m = u_q.size() - 1;
          exp_q.push_back(conv(m));
          u_q.push_back(0);
          exp_q.push_back(conv(m + 1));
        end
      end
    end
  end

  task automatic push(input int v);
    int unsigned t = 0;
    in_valid = 1'b1;
    in_data  = 8'(v);
    @(negedge clk);
    while (!in_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) check("push_timeout", 0, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_data  = 8'sh5A;
  endtask

  task automatic drain();
    int unsigned t = 0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    while ((exp_q.size() != 0 || out_valid) && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (exp_q.size() != 0 || out_valid) check("drain_timeout", 0, 1);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    log_q.delete();
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_in_ready", int'(in_ready), 1);
    check("rst_out_data", int'(out_data), 0);
  endtask

  task automatic check_seq(input string name, input int exp_v[8], input int n, input int off);
    for (int i = 0; i < n; i++) begin
      if (off + i < 0 || off + i >= log_q.size()) check({name, "_missing"}, 0, 1);
      else check(name, log_q[off + i], exp_v[i]);
    end
  endtask

  initial begin : main
    int e[8];
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check("init_out_valid", int'(out_valid), 0);
    check("init_in_ready", int'(in_ready), 1);
    check("init_out_data", int'(out_data), 0);

    // Impulse
    do_reset();
    push(64); push(0); push(0); push(0);
    drain();
    e = '{64, 128, 256, 128, 64, 0, 0, 0};
    check("impulse_len", log_q.size(), 8);
    check_seq("impulse", e, 8, 0);

    // Idle gap keeps history
    do_reset();
    push(64);
    drain();
    repeat (5) @(posedge clk);
    #1;
    check("idle_out_valid", int'(out_valid), 0);
    check("idle_in_ready", int'(in_ready), 1);
    push(0);
    drain();
    e = '{64, 128, 256, 128, 0, 0, 0, 0};
    check_seq("idle_gap", e, 4, 0);

    // DC stream without bubbles
    do_reset();
    push(10); push(10);
    streaming = 1'b1;
    for (int i = 0; i < 6; i++) push(10);
    streaming = 1'b0;
    drain();
    check("dc_bubbles", bubbles, 0);
    e = '{60, 40, 60, 40, 0, 0, 0, 0};
    check_seq("dc_tail", e, 4, log_q.size() - 4);

    // Extremes
    do_reset();
    for (int i = 0; i < 4; i++) push(-128);
    drain();
    e = '{-768, -512, 0, 0, 0, 0, 0, 0};
    check_seq("neg_extreme", e, 2, log_q.size() - 2);
    do_reset();
    for (int i = 0; i < 4; i++) push(127);
    drain();
    e = '{762, 508, 0, 0, 0, 0, 0, 0};
    check_seq("pos_extreme", e, 2, log_q.size() - 2);

    // Backpressure in EMIT_EVEN; offered input must be ignored
    do_reset();
    push(64);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 8'sd99;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check("bp_out_valid", int'(out_valid), 1);
      check("bp_out_data", int'(out_data), 64);
      check("bp_in_ready", int'(in_ready), 0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("bp_release_data", int'(out_data), 128);
    check("bp_release_valid", int'(out_valid), 1);
    push(0);
    drain();
    e = '{64, 128, 256, 128, 0, 0, 0, 0};
    check_seq("backpressure", e, 4, 0);

    // Reset while EMIT_ODD is presenting data
    do_reset();
    push(64);
    push(0);
    @(posedge clk);
    #1;
    check("mid_odd_valid", int'(out_valid), 1);
    check("mid_odd_data", int'(out_data), 128);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("mid_rst_out_valid", int'(out_valid), 0);
    check("mid_rst_in_ready", int'(in_ready), 1);
    log_q.delete();
    push(64);
    drain();
    e = '{64, 128, 0, 0, 0, 0, 0, 0};
    check("mid_rst_len", log_q.size(), 2);
    check_seq("mid_rst", e, 2, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
